// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: sequences multi-cycle reads and writes to the
// external async SRAM (RAM1) and the memory-mapped UART sharing its data bus,
// stalling the pipeline until each access has completed.
module mem_access_ctrl #(
  parameter int          RD_WAIT        = 2,
  parameter int          WR_PULSE       = 2,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        em_RAM_en,
  input  logic        em_RAM_op,
  input  logic [15:0] em_ALU_data,
  input  logic [15:0] em_RAM_WB_data,
  output logic        mem_stall,
  output logic [15:0] mem_rdata,
  output logic [17:0] ram1_addr,
  inout  wire  [15:0] ram1_data,
  output logic        ram1_ce_n,
  output logic        ram1_oe_n,
  output logic        ram1_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
  localparam logic [2:0] WR_CNT = 3'(WR_PULSE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACC,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  state_t      r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic [15:0] r_rdata, w_rdata_next;
  logic        r_ce_n, r_oe_n, r_we_n, r_rdn, r_wrn, r_drive;
  logic        w_ce_n_next, w_oe_n_next, w_we_n_next, w_rdn_next, w_wrn_next, w_drive_next;
  logic        w_is_uart, w_is_stat, w_next_busy, w_next_wr;

  // EXE/MEM is frozen by mem_stall, so the target can be decoded live every cycle.
  assign w_is_uart = (em_ALU_data == UART_DATA_ADDR);
  assign w_is_stat = (em_ALU_data == UART_STAT_ADDR);

  assign ram1_addr = {2'b00, em_ALU_data};
  assign ram1_data = r_drive ? em_RAM_WB_data : 16'bz;
  assign ram1_ce_n = r_ce_n;
  assign ram1_oe_n = r_oe_n;
  assign ram1_we_n = r_we_n;
  assign uart_rdn  = r_rdn;
  assign uart_wrn  = r_wrn;
  assign mem_rdata = r_rdata;

  // Stall covers the request cycle in IDLE and every bus-active state; DONE lets the pipeline advance.
  assign mem_stall = !rst && ((r_state == S_IDLE && em_RAM_en) ||
                              (r_state != S_IDLE && r_state != S_DONE));

  // Next-state, counter and load-data selection.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rdata_next = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (em_RAM_en) begin
          if (w_is_stat) begin
            if (!em_RAM_op)
              w_rdata_next = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
            w_state_next = S_DONE;
          end else if (!em_RAM_op) begin
            w_state_next = S_RD_ACC;
            w_cnt_next   = RD_CNT;
          end else begin
            w_state_next = S_WR_SETUP;
          end
        end
      end
      S_RD_ACC: begin
        if (r_cnt == 3'd1) begin
          w_rdata_next = w_is_uart ? {8'b0, ram1_data[7:0]} : ram1_data;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_WR_SETUP: begin
        w_state_next = S_WR_PULSE;
        w_cnt_next   = WR_CNT;
      end
      S_WR_PULSE: begin
        if (r_cnt == 3'd1)
          w_state_next = S_WR_HOLD;
        else
          w_cnt_next = r_cnt - 3'd1;
      end
      S_WR_HOLD: w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Strobes are derived from the state being entered so they register glitch-free alongside it.
  always_comb begin
    w_next_wr    = (w_state_next == S_WR_SETUP) || (w_state_next == S_WR_PULSE) ||
                   (w_state_next == S_WR_HOLD);
    w_next_busy  = w_next_wr || (w_state_next == S_RD_ACC);
    w_ce_n_next  = !(w_next_busy && !w_is_uart);
    w_oe_n_next  = !((w_state_next == S_RD_ACC) && !w_is_uart);
    w_rdn_next   = !((w_state_next == S_RD_ACC) && w_is_uart);
    w_we_n_next  = !((w_state_next == S_WR_PULSE) && !w_is_uart);
    w_wrn_next   = !((w_state_next == S_WR_PULSE) && w_is_uart);
    w_drive_next = w_next_wr;
  end

  // State, counter, strobe and load-result registers.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= 16'd0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_rdn   <= 1'b1;
      r_wrn   <= 1'b1;
      r_drive <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rdata <= w_rdata_next;
      r_ce_n  <= w_ce_n_next;
      r_oe_n  <= w_oe_n_next;
      r_we_n  <= w_we_n_next;
      r_rdn   <= w_rdn_next;
      r_wrn   <= w_wrn_next;
      r_drive <= w_drive_next;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: SRAM/UART device models on the shared bus, a
// pipeline-style driver that advances only when stall is low, and a
// reference model of the expected per-access strobe counts and load results.
module tb_mem_access_ctrl;

  localparam int          RD_WAIT  = 2;
  localparam int          WR_PULSE = 2;
  localparam logic [15:0] UDATA    = 16'hBF00;
  localparam logic [15:0] USTAT    = 16'hBF01;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic        em_RAM_en = 1'b0;
  logic        em_RAM_op = 1'b0;
  logic [15:0] em_ALU_data = 16'd0;
  logic [15:0] em_RAM_WB_data = 16'd0;
  logic        mem_stall;
  logic [15:0] mem_rdata;
  logic [17:0] ram1_addr;
  wire  [15:0] ram1_data;
  logic        ram1_ce_n, ram1_oe_n, ram1_we_n, uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0;

  int checks = 0;
  int failures = 0;

  // device models
  logic [15:0] dev_mem [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] uart_rx_val = 16'd0;
  logic [7:0]  uart_tx_val = 8'd0;
  int          sram_wr_events = 0, uart_wr_events = 0;
  logic        prev_we_n = 1'b1, prev_wrn = 1'b1;
  logic        tb_drive;
  logic [15:0] tb_val;

  // measurements of one access
  int          m_stall, m_oe, m_rdn, m_we, m_wrn, m_ce, m_drv, m_rdbad;
  logic        m_timeout, m_addr_ok;
  logic [1:0]  m_first_drv_strb;
  logic [15:0] m_rdata;
  int          m_sram_wr, m_uart_wr;

  always #10 clk_50MHz = ~clk_50MHz;

  mem_access_ctrl #(
    .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE),
    .UART_DATA_ADDR(UDATA), .UART_STAT_ADDR(USTAT)
  ) dut (
    .clk_50MHz(clk_50MHz), .rst(rst),
    .em_RAM_en(em_RAM_en), .em_RAM_op(em_RAM_op),
    .em_ALU_data(em_ALU_data), .em_RAM_WB_data(em_RAM_WB_data),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .ram1_addr(ram1_addr), .ram1_data(ram1_data),
    .ram1_ce_n(ram1_ce_n), .ram1_oe_n(ram1_oe_n), .ram1_we_n(ram1_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  assign tb_drive  = (!ram1_ce_n && !ram1_oe_n) || !uart_rdn;
  assign tb_val    = !uart_rdn ? uart_rx_val : dev_mem[ram1_addr[7:0]];
  assign ram1_data = tb_drive ? tb_val : 16'bz;

  // SRAM and UART write capture, sampled mid-cycle
  always @(negedge clk_50MHz) begin
    if (!ram1_we_n && !ram1_ce_n) dev_mem[ram1_addr[7:0]] = ram1_data;
    if (!uart_wrn) uart_tx_val = ram1_data[7:0];
    if (!prev_we_n && ram1_we_n) sram_wr_events = sram_wr_events + 1;
    if (!prev_wrn && uart_wrn) uart_wr_events = uart_wr_events + 1;
    prev_we_n = ram1_we_n;
    prev_wrn  = uart_wrn;
  end

  // Present one instruction in EXE/MEM and hold it until stall drops (the DONE cycle).
  task automatic run_access(input logic en, input logic op, input logic [15:0] addr,
                            input logic [15:0] wdata);
    int sw0, uw0;
    bit first;
    @(negedge clk_50MHz);
    em_RAM_en = en; em_RAM_op = op; em_ALU_data = addr; em_RAM_WB_data = wdata;
    sw0 = sram_wr_events; uw0 = uart_wr_events;
    m_stall = 0; m_oe = 0; m_rdn = 0; m_we = 0; m_wrn = 0; m_ce = 0; m_drv = 0; m_rdbad = 0;
    m_timeout = 1'b1; m_addr_ok = 1'b1; m_first_drv_strb = 2'b00; first = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (ram1_addr !== {2'b00, addr}) m_addr_ok = 1'b0;
      if (!ram1_oe_n) m_oe++;
      if (!uart_rdn)  m_rdn++;
      if (!ram1_we_n) m_we++;
      if (!uart_wrn)  m_wrn++;
      if (!ram1_ce_n) m_ce++;
      if (!tb_drive && ram1_data === wdata) begin
        if (first) m_first_drv_strb = {ram1_we_n, uart_wrn};
        first = 1'b0;
        m_drv++;
      end
      if (!ram1_oe_n && !ram1_ce_n && ram1_data !== dev_mem[ram1_addr[7:0]]) m_rdbad++;
      if (!mem_stall) begin
        m_timeout = 1'b0;
        break;
      end
      m_stall++;
      @(negedge clk_50MHz);
    end
    m_rdata   = mem_rdata;
    m_sram_wr = sram_wr_events - sw0;
    m_uart_wr = uart_wr_events - uw0;
  endtask

  task automatic test_reset;
    rst = 1'b1; em_RAM_en = 1'b1; em_RAM_op = 1'b0; em_ALU_data = 16'h0010;
    repeat (3) @(posedge clk_50MHz);
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", mem_stall); end
    checks++;
    if ({ram1_ce_n, ram1_oe_n, ram1_we_n, uart_rdn, uart_wrn} !== 5'b11111) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=11111", {ram1_ce_n, ram1_oe_n, ram1_we_n, uart_rdn, uart_wrn});
    end
    checks++;
    if (mem_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h want=0000", mem_rdata); end
    em_RAM_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sram_store;
    run_access(1'b1, 1'b1, 16'h0040, 16'hA5C3);
    ref_mem[8'h40] = 16'hA5C3;
    checks++;
    if (m_timeout) begin failures++; $display("FAIL store_timeout got=timeout want=done"); end
    checks++;
    if (m_we !== WR_PULSE) begin failures++; $display("FAIL store_we_low got=%0d want=%0d", m_we, WR_PULSE); end
    checks++;
    if (m_drv !== WR_PULSE + 2) begin failures++; $display("FAIL store_bus_cycles got=%0d want=%0d", m_drv, WR_PULSE + 2); end
    checks++;
    if (m_stall !== WR_PULSE + 3) begin failures++; $display("FAIL store_stall got=%0d want=%0d", m_stall, WR_PULSE + 3); end
    checks++;
    if (m_first_drv_strb !== 2'b11) begin failures++; $display("FAIL store_setup_strobes got=%b want=11", m_first_drv_strb); end
    checks++;
    if (!m_addr_ok) begin failures++; $display("FAIL store_addr got=%h want=00040", ram1_addr); end
    checks++;
    if (m_sram_wr !== 1 || dev_mem[8'h40] !== 16'hA5C3) begin
      failures++; $display("FAIL store_mem got=%0d/%h want=1/a5c3", m_sram_wr, dev_mem[8'h40]);
    end
  endtask

  task automatic test_sram_load;
    run_access(1'b1, 1'b0, 16'h0040, 16'h1357);
    checks++;
    if (m_rdata !== 16'hA5C3) begin failures++; $display("FAIL load_rdata got=%h want=a5c3", m_rdata); end
    checks++;
    if (m_oe !== RD_WAIT) begin failures++; $display("FAIL load_oe_low got=%0d want=%0d", m_oe, RD_WAIT); end
    checks++;
    if (m_stall !== RD_WAIT + 1) begin failures++; $display("FAIL load_stall got=%0d want=%0d", m_stall, RD_WAIT + 1); end
  endtask

  task automatic test_uart_load;
    uart_rx_val = 16'hFF5A;
    run_access(1'b1, 1'b0, UDATA, 16'h1357);
    checks++;
    if (m_rdata !== 16'h005A) begin failures++; $display("FAIL uart_rdata got=%h want=005a", m_rdata); end
    checks++;
    if (m_ce !== 0 || m_rdn !== RD_WAIT) begin
      failures++; $display("FAIL uart_strobes got=ce%0d/rdn%0d want=ce0/rdn%0d", m_ce, m_rdn, RD_WAIT);
    end
  endtask

  task automatic test_status_load;
    uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
    run_access(1'b1, 1'b0, USTAT, 16'h1357);
    checks++;
    if (m_rdata !== 16'h0002) begin failures++; $display("FAIL status_rdata got=%h want=0002", m_rdata); end
    checks++;
    if (m_stall !== 1 || (m_ce + m_oe + m_we + m_rdn + m_wrn) !== 0) begin
      failures++; $display("FAIL status_activity got=stall%0d/strb%0d want=stall1/strb0", m_stall, m_ce + m_oe + m_we + m_rdn + m_wrn);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    d = 16'($urandom_range(1, 16'hFFFF));
    run_access(1'b1, 1'b1, 16'h0021, d);
    ref_mem[8'h21] = d;
    checks++;
    if (m_sram_wr !== 1 || m_oe !== 0) begin failures++; $display("FAIL b2b_store got=wr%0d/oe%0d want=wr1/oe0", m_sram_wr, m_oe); end
    run_access(1'b1, 1'b0, 16'h0021, ~d);
    checks++;
    if (m_rdata !== d || m_sram_wr !== 0 || m_oe !== RD_WAIT || m_rdbad !== 0) begin
      failures++; $display("FAIL b2b_load got=%h wr%0d oe%0d bad%0d want=%h wr0 oe%0d bad0", m_rdata, m_sram_wr, m_oe, m_rdbad, d, RD_WAIT);
    end
  endtask

  task automatic test_random;
    logic [15:0] exp_rdata, addr, wd;
    int kind, e_stall, e_oe, e_rdn, e_we, e_wrn, e_ce, e_drv, e_sw, e_uw;
    logic en, op;
    exp_rdata = mem_rdata;
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 6));
      wd = 16'($urandom_range(1, 16'hFFFF));
      uart_rx_val = 16'($urandom);
      uart_data_ready = 1'($urandom); uart_tbre = 1'($urandom); uart_tsre = 1'($urandom);
      en = (kind != 6); op = (kind == 1 || kind == 3 || kind == 5);
      addr = (kind <= 1) ? 16'($urandom_range(0, 127)) :
             (kind <= 3) ? UDATA : (kind <= 5) ? USTAT : 16'($urandom);
      e_stall = 0; e_oe = 0; e_rdn = 0; e_we = 0; e_wrn = 0; e_ce = 0; e_drv = 0; e_sw = 0; e_uw = 0;
      case (kind)
        0: begin e_stall = 1 + RD_WAIT; e_oe = RD_WAIT; e_ce = RD_WAIT; exp_rdata = ref_mem[addr[7:0]]; end
        1: begin e_stall = 3 + WR_PULSE; e_we = WR_PULSE; e_ce = WR_PULSE + 2; e_drv = WR_PULSE + 2; e_sw = 1; ref_mem[addr[7:0]] = wd; end
        2: begin e_stall = 1 + RD_WAIT; e_rdn = RD_WAIT; exp_rdata = {8'h00, uart_rx_val[7:0]}; end
        3: begin e_stall = 3 + WR_PULSE; e_wrn = WR_PULSE; e_drv = WR_PULSE + 2; e_uw = 1; end
        4: begin e_stall = 1; exp_rdata = {14'b0, uart_data_ready, uart_tbre & uart_tsre}; end
        5: e_stall = 1;
        default: e_stall = 0;
      endcase
      run_access(en, op, addr, wd);
      $display("txn %0d kind=%0d addr=%h wdata=%h rdata=%h stall=%0d", t, kind, addr, wd, m_rdata, m_stall);
      checks++;
      if (m_timeout) begin failures++; $display("FAIL rnd_timeout txn=%0d got=timeout want=done", t); end
      checks++;
      if (m_rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata txn=%0d got=%h want=%h", t, m_rdata, exp_rdata); end
      checks++;
      if (m_stall !== e_stall) begin failures++; $display("FAIL rnd_stall txn=%0d got=%0d want=%0d", t, m_stall, e_stall); end
      checks++;
      if ({m_oe, m_rdn, m_we, m_wrn, m_ce} !== {e_oe, e_rdn, e_we, e_wrn, e_ce}) begin
        failures++;
        $display("FAIL rnd_strobes txn=%0d got=oe%0d rdn%0d we%0d wrn%0d ce%0d want=oe%0d rdn%0d we%0d wrn%0d ce%0d",
                 t, m_oe, m_rdn, m_we, m_wrn, m_ce, e_oe, e_rdn, e_we, e_wrn, e_ce);
      end
      checks++;
      if (m_drv !== e_drv || m_rdbad !== 0) begin failures++; $display("FAIL rnd_bus txn=%0d got=drv%0d bad%0d want=drv%0d bad0", t, m_drv, m_rdbad, e_drv); end
      checks++;
      if (m_sram_wr !== e_sw || m_uart_wr !== e_uw) begin
        failures++; $display("FAIL rnd_writes txn=%0d got=%0d/%0d want=%0d/%0d", t, m_sram_wr, m_uart_wr, e_sw, e_uw);
      end
      if (kind == 3) begin
        checks++;
        if (uart_tx_val !== wd[7:0]) begin failures++; $display("FAIL rnd_uart_tx txn=%0d got=%h want=%h", t, uart_tx_val, wd[7:0]); end
      end
    end
  endtask

  task automatic test_reset_mid_access;
    bit hit;
    hit = 1'b0;
    @(negedge clk_50MHz);
    em_RAM_en = 1'b1; em_RAM_op = 1'b1; em_ALU_data = 16'h00F0; em_RAM_WB_data = 16'h6E6E;
    ref_mem[8'hF0] = 16'h6E6E;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!ram1_we_n) begin hit = 1'b1; break; end
      @(negedge clk_50MHz);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL midrst_reach_pulse got=no_we want=we_low"); end
    checks++;
    if (mem_rdata === 16'h0000) begin failures++; $display("FAIL midrst_precond got=%h want=nonzero", mem_rdata); end
    rst = 1'b1;
    @(posedge clk_50MHz); #1;
    checks++;
    if (ram1_we_n !== 1'b1 || ram1_ce_n !== 1'b1) begin failures++; $display("FAIL midrst_strobes got=we%b ce%b want=we1 ce1", ram1_we_n, ram1_ce_n); end
    checks++;
    if (!tb_drive && ram1_data === 16'h6E6E) begin failures++; $display("FAIL midrst_bus got=%h want=released", ram1_data); end
    checks++;
    if (mem_stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b want=0", mem_stall); end
    checks++;
    if (mem_rdata !== 16'h0000) begin failures++; $display("FAIL midrst_rdata got=%h want=0000", mem_rdata); end
    @(posedge clk_50MHz); #1;
    rst = 1'b0; em_RAM_en = 1'b0;
    @(negedge clk_50MHz); #1;
    checks++;
    if (mem_stall !== 1'b0 || ram1_we_n !== 1'b1) begin failures++; $display("FAIL midrst_after got=stall%b we%b want=stall0 we1", mem_stall, ram1_we_n); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 16'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    test_reset();
    test_sram_store();
    test_sram_load();
    test_uart_load();
    test_status_load();
    test_back_to_back();
    test_random();
    run_access(1'b1, 1'b0, 16'h0040, 16'h0001);
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
